snake_head_stepper: RTL and testbench

//  Consumes the debounced 2-bit direction (0=UP,1=LEFT,2=DOWN,3=RIGHT) from the input controller and advances the snake head one cell per game tick.

---
 rtl/snake_pkg.sv | 19 +
 rtl/turn_queue.sv | 51 +++++
 rtl/snake_head_stepper.sv | 112 +++++++++++
 tb/tb_snake_head_stepper.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: direction and game-state encodings shared by the snake input controller and head stepper.
package snake_pkg;
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    // Opposite directions differ only in bit 1 with this encoding.
    function automatic logic is_opposite(input logic [1:0] newd, input logic [1:0] curd);
        return (newd ^ curd) == 2'b10;
    endfunction
endpackage

// File: rtl/turn_queue.sv
// turn_queue: shift-register FIFO of pending turns; dout is the oldest entry, tail the newest.
module turn_queue #(
    parameter int QDEPTH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  logic [1:0] din,
    output logic [1:0] dout,
    output logic [1:0] tail,
    output logic       empty,
    output logic       full
);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [1:0]    mem   [QDEPTH];
    logic [1:0]    mem_n [QDEPTH];
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign empty   = cnt == '0;
    assign full    = cnt == CW'(QDEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[0];

    // The write slot accounts for a same-cycle pop shifting everything down.
    always_comb begin
        tail  = mem[0];
        mem_n = mem;
        for (int i = 0; i < QDEPTH; i++)
            if (CW'(i + 1) == cnt) tail = mem[i];
        for (int i = 0; i < QDEPTH - 1; i++)
            if (do_pop) mem_n[i] = mem[i + 1];
        for (int i = 0; i < QDEPTH; i++)
            if (do_push && CW'(i) == cnt - CW'(do_pop)) mem_n[i] = din;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt <= '0;
            for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
            mem <= mem_n;
        end
endmodule

// File: rtl/snake_head_stepper.sv
// snake_head_stepper: advances the snake head one cell per game tick, buffering turns between ticks.
// Define SNAKE_WRAP_EN to wrap at the playfield edges instead of dying on a wall hit.
module snake_head_stepper
    import snake_pkg::*;
#(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int TICK_DIV = 2500000,
    parameter int QDEPTH   = 2,
    localparam int X_W     = $clog2(GRID_W),
    localparam int Y_W     = $clog2(GRID_H)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [1:0]     dir,
    input  logic           start,
    input  logic           pause,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [1:0]     head_dir,
    output logic           step,
    output logic [1:0]     state,
    output logic           hit_wall
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_MID = X_W'(GRID_W / 2);
    localparam logic [Y_W-1:0] Y_MID = Y_W'(GRID_H / 2);

    state_t         st, st_n;
    logic [CW-1:0]  cnt;
    logic [1:0]     dir_q, q_dout, q_tail, ref_dir, new_dir;
    logic           q_empty, q_full, tick, wall, push;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;

    assign state   = st;
    assign tick    = st == ST_RUN && cnt == CW'(TICK_DIV - 1);
    assign new_dir = q_empty ? head_dir : q_dout;
    // With a single entry being popped, tail equals the new head_dir, so this covers the pop case too.
    assign ref_dir = q_empty ? head_dir : q_tail;
    assign push    = (st == ST_RUN || st == ST_PAUSE) && !start && dir != dir_q
                     && dir != ref_dir && !is_opposite(dir, ref_dir) && (!q_full || tick);

    assign nx = new_dir == DIR_LEFT  ? (head_x == '0 ? X_MAX : head_x - 1'b1) :
                new_dir == DIR_RIGHT ? (head_x == X_MAX ? '0 : head_x + 1'b1) : head_x;
    assign ny = new_dir == DIR_UP    ? (head_y == '0 ? Y_MAX : head_y - 1'b1) :
                new_dir == DIR_DOWN  ? (head_y == Y_MAX ? '0 : head_y + 1'b1) : head_y;
`ifdef SNAKE_WRAP_EN
    assign wall = 1'b0;
`else
    assign wall = new_dir == DIR_UP   ? head_y == '0 :
                  new_dir == DIR_LEFT ? head_x == '0 :
                  new_dir == DIR_DOWN ? head_y == Y_MAX : head_x == X_MAX;
`endif

    turn_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (tick),
        .clear   (start),
        .din     (dir),
        .dout    (q_dout),
        .tail    (q_tail),
        .empty   (q_empty),
        .full    (q_full)
    );

    always_comb begin
        st_n = st;
        if (start) st_n = ST_RUN;
        else if (st == ST_RUN) st_n = tick && wall ? ST_DEAD : pause ? ST_PAUSE : ST_RUN;
        else if (st == ST_PAUSE) st_n = pause ? ST_PAUSE : ST_RUN;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            st       <= ST_IDLE;
            head_x   <= X_MID;
            head_y   <= Y_MID;
            head_dir <= DIR_RIGHT;
            step     <= 1'b0;
            hit_wall <= 1'b0;
            cnt      <= '0;
            dir_q    <= DIR_RIGHT;
        end else begin
            st    <= st_n;
            dir_q <= dir;
            step  <= 1'b0;
            if (start) begin
                head_x   <= X_MID;
                head_y   <= Y_MID;
                head_dir <= DIR_RIGHT;
                hit_wall <= 1'b0;
                cnt      <= '0;
            end else if (st == ST_RUN) begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick) begin
                    head_dir <= new_dir;
                    if (wall) begin
                        hit_wall <= 1'b1;
                    end else begin
                        head_x <= nx;
                        head_y <= ny;
                        step   <= 1'b1;
                    end
                end
            end
        end
endmodule

// File: tb/tb_snake_head_stepper.sv
// tb_snake_head_stepper: scoreboard bench on an 8x6 grid, TICK_DIV=4, QDEPTH=2.
module tb_snake_head_stepper;
    localparam int GW = 8, GH = 6, TD = 4, QD = 2;

    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, pause = 1'b0;
    logic [1:0] dir = 2'd3;
    logic [2:0] head_x, head_y;
    logic [1:0] head_dir, state;
    logic       step, hit_wall;
    int         passed = 0, total = 0;

    typedef struct packed {logic [2:0] x; logic [2:0] y; logic [1:0] d;} exp_t;
    exp_t sb[$];
    exp_t e;

    snake_head_stepper #(.GRID_W(GW), .GRID_H(GH), .TICK_DIV(TD), .QDEPTH(QD)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .dir      (dir),
        .start    (start),
        .pause    (pause),
        .head_x   (head_x),
        .head_y   (head_y),
        .head_dir (head_dir),
        .step     (step),
        .state    (state),
        .hit_wall (hit_wall)
    );

    always #5 clk = ~clk;

    // Every step pulse pops the next expected head position.
    always @(negedge clk)
        if (reset_n && step) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_step unexpected step got (%0d,%0d,%0d) want no step", head_x, head_y, head_dir);
            end else begin
                e = sb.pop_front();
                if ({head_x, head_y, head_dir} !== {e.x, e.y, e.d})
                    $display("FAIL sb_step got (%0d,%0d,%0d) want (%0d,%0d,%0d)", head_x, head_y, head_dir, e.x, e.y, e.d);
                else passed++;
            end
        end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic wait_step(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step && n < budget);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; pause = 1'b0; dir = 2'd3;
        repeat (2) @(negedge clk);
        total++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
        total++; if ({head_x, head_y} !== {3'd4, 3'd3}) $display("FAIL reset_head got (%0d,%0d) want (4,3)", head_x, head_y); else passed++;
        total++; if (head_dir !== 2'd3) $display("FAIL reset_dir got %0d want 3", head_dir); else passed++;
        total++; if ({step, hit_wall} !== 2'b00) $display("FAIL reset_flags got %b want 00", {step, hit_wall}); else passed++;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (state !== 2'd0) $display("FAIL idle_hold got %0d want 0", state); else passed++;
    endtask

    task automatic test_start_steps();
        int n;
        start = 1'b1; dir = 2'd3;
        @(negedge clk);
        start = 1'b0;
        total++; if (state !== 2'd1) $display("FAIL start_state got %0d want 1", state); else passed++;
        total++; if ({head_x, head_y, head_dir} !== {3'd4, 3'd3, 2'd3}) $display("FAIL start_head got (%0d,%0d,%0d) want (4,3,3)", head_x, head_y, head_dir); else passed++;
        sb.push_back({3'd5, 3'd3, 2'd3});
        sb.push_back({3'd6, 3'd3, 2'd3});
        sb.push_back({3'd7, 3'd3, 2'd3});
        for (int i = 0; i < 3; i++) begin
            wait_step(8, n);
            total++; if (n !== 4) $display("FAIL step_interval_%0d got %0d want 4", i, n); else passed++;
        end
    endtask

    task automatic test_wall();
        int n;
`ifdef SNAKE_WRAP_EN
        sb.push_back({3'd0, 3'd3, 2'd3});
        wait_step(8, n);
        total++; if (n !== 4) $display("FAIL wrap_interval got %0d want 4", n); else passed++;
        total++; if ({state, hit_wall} !== {2'd1, 1'b0}) $display("FAIL wrap_state got %0d/%b want 1/0", state, hit_wall); else passed++;
`else
        repeat (4) @(negedge clk);
        total++; if ({state, hit_wall} !== {2'd3, 1'b1}) $display("FAIL wall_state got %0d/%b want 3/1", state, hit_wall); else passed++;
        total++; if ({head_x, head_y, head_dir, step} !== {3'd7, 3'd3, 2'd3, 1'b0}) $display("FAIL wall_head got (%0d,%0d,%0d) step %b want (7,3,3) step 0", head_x, head_y, head_dir, step); else passed++;
        repeat (6) @(negedge clk);
        total++; if ({state, head_x} !== {2'd3, 3'd7}) $display("FAIL dead_hold got %0d x %0d want 3 x 7", state, head_x); else passed++;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if ({state, hit_wall} !== {2'd1, 1'b0}) $display("FAIL restart_state got %0d/%b want 1/0", state, hit_wall); else passed++;
        total++; if ({head_x, head_y, head_dir} !== {3'd4, 3'd3, 2'd3}) $display("FAIL restart_head got (%0d,%0d,%0d) want (4,3,3)", head_x, head_y, head_dir); else passed++;
    endtask

    task automatic test_reverse();
        int n;
        dir = 2'd1;
        @(negedge clk);
        dir = 2'd3;
        sb.push_back({3'd5, 3'd3, 2'd3});
        wait_step(8, n);
        total++; if (n !== 3) $display("FAIL reverse_interval got %0d want 3", n); else passed++;
    endtask

    task automatic test_queue();
        int n;
        dir = 2'd0;
        sb.push_back({3'd5, 3'd2, 2'd0});
        sb.push_back({3'd4, 3'd2, 2'd1});
        sb.push_back({3'd3, 3'd2, 2'd1});
        @(negedge clk);
        dir = 2'd1;
        @(negedge clk);
        dir = 2'd2;
        wait_step(8, n);
        total++; if (n !== 2) $display("FAIL queue_first got %0d want 2", n); else passed++;
        for (int i = 0; i < 2; i++) begin
            wait_step(8, n);
            total++; if (n !== 4) $display("FAIL queue_next_%0d got %0d want 4", i, n); else passed++;
        end
    endtask

    task automatic test_pause();
        int n, s;
        s = 0;
        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (step) s++;
        end
        total++; if (s !== 0) $display("FAIL pause_steps got %0d want 0", s); else passed++;
        total++; if (state !== 2'd2) $display("FAIL pause_state got %0d want 2", state); else passed++;
        pause = 1'b0;
        sb.push_back({3'd2, 3'd2, 2'd1});
        wait_step(8, n);
        total++; if (n !== 3) $display("FAIL pause_resume got %0d want 3", n); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if ({state, head_x, head_y, head_dir} !== {2'd1, 3'd4, 3'd3, 2'd3}) $display("FAIL run_restart got %0d (%0d,%0d,%0d) want 1 (4,3,3)", state, head_x, head_y, head_dir); else passed++;
        sb.push_back({3'd5, 3'd3, 2'd3});
        wait_step(8, n);
        total++; if (n !== 4) $display("FAIL run_restart_interval got %0d want 4", n); else passed++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++; if ({state, head_x, head_y, head_dir, step} !== {2'd0, 3'd4, 3'd3, 2'd3, 1'b0}) $display("FAIL async_reset got %0d (%0d,%0d,%0d) step %b want 0 (4,3,3) step 0", state, head_x, head_y, head_dir, step); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        total++; if ({state, head_x} !== {2'd0, 3'd4}) $display("FAIL post_reset_idle got %0d x %0d want 0 x 4", state, head_x); else passed++;
    endtask

    initial begin
        test_reset();
        test_start_steps();
        test_wall();
        test_reverse();
        test_queue();
        test_pause();
        test_back_to_back();
        test_async_reset();
        total++; if (sb.size() !== 0) $display("FAIL sb_drain got %0d pending want 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
